// File: rtl/xor_lane_pipe_if.sv
// ============================================================================
// Module      : xor_lane_pipe_if
// Description : Stream bundle between a producer/consumer and xor_lane_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface xor_lane_pipe_if #(
    parameter int WIDTH = 8,
    parameter int LANES = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic [1:0]               mode;
    logic                     acc_clr;
    logic [WIDTH*LANES-1:0]   a;
    logic [WIDTH*LANES-1:0]   b;
    logic [WIDTH*LANES-1:0]   out_comb;
    logic [WIDTH*LANES-1:0]   out_data;
    logic [LANES-1:0]         out_parity;
    logic                     out_valid;
    logic                     out_ready;

    modport master (
        output in_valid, mode, acc_clr, a, b, out_ready,
        input  in_ready, out_comb, out_data, out_parity, out_valid
    );

    modport slave (
        input  in_valid, mode, acc_clr, a, b, out_ready,
        output in_ready, out_comb, out_data, out_parity, out_valid
    );
endinterface

`default_nettype wire

// File: rtl/xor_lane_pipe.sv
// ============================================================================
// Module      : xor_lane_pipe
// Description : Multi-lane XOR/XNOR/accumulate/pass datapath with a stallable
//               valid/ready pipeline and per-lane output parity.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module xor_lane_pipe #(
    parameter int WIDTH  = 8,
    parameter int LANES  = 4,
    parameter int STAGES = 2
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    xor_lane_pipe_if.slave  bus
);
    localparam int         TOTAL      = WIDTH * LANES;
    localparam logic [1:0] MODE_XOR   = 2'b00;
    localparam logic [1:0] MODE_XNOR  = 2'b01;
    localparam logic [1:0] MODE_ACCUM = 2'b10;
    localparam logic [1:0] MODE_PASS  = 2'b11;

    logic              advance;
    logic              accept;
    logic [TOTAL-1:0]  result;
    logic [TOTAL-1:0]  acc_q;
    logic [TOTAL-1:0]  acc_d;
    logic [STAGES-1:0] vld_q;
    logic [TOTAL-1:0]  data_q [STAGES];

    // Global stall: the whole pipe moves only when the tail can drain.
    assign advance      = !vld_q[STAGES-1] || bus.out_ready;
    assign accept       = bus.in_valid && advance;
    assign bus.in_ready = advance;
    assign bus.out_comb = bus.a ^ bus.b;

    generate
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            logic [WIDTH-1:0] a_l;
            logic [WIDTH-1:0] b_l;
            logic [WIDTH-1:0] acc_base;
            logic [WIDTH-1:0] acc_next;

            assign a_l      = bus.a[l*WIDTH +: WIDTH];
            assign b_l      = bus.b[l*WIDTH +: WIDTH];
            // Clear takes effect before a coincident accumulate beat.
            assign acc_base = bus.acc_clr ? '0 : acc_q[l*WIDTH +: WIDTH];
            assign acc_next = acc_base ^ a_l ^ b_l;

            always_comb begin
                result[l*WIDTH +: WIDTH] = a_l ^ b_l;
                case (bus.mode)
                    MODE_XOR:   result[l*WIDTH +: WIDTH] = a_l ^ b_l;
                    MODE_XNOR:  result[l*WIDTH +: WIDTH] = ~(a_l ^ b_l);
                    MODE_ACCUM: result[l*WIDTH +: WIDTH] = acc_next;
                    MODE_PASS:  result[l*WIDTH +: WIDTH] = a_l;
                    default:    result[l*WIDTH +: WIDTH] = a_l ^ b_l;
                endcase
            end

            always_comb begin
                acc_d[l*WIDTH +: WIDTH] = acc_base;
                if (accept && (bus.mode == MODE_ACCUM)) begin
                    acc_d[l*WIDTH +: WIDTH] = acc_next;
                end
            end

            assign bus.out_parity[l] = ^data_q[STAGES-1][l*WIDTH +: WIDTH];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    generate
        for (genvar s = 0; s < STAGES; s++) begin : g_stage
            if (s == 0) begin : g_head
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        vld_q[0]  <= 1'b0;
                        data_q[0] <= '0;
                    end else if (advance) begin
                        vld_q[0]  <= bus.in_valid;
                        data_q[0] <= result;
                    end
                end
            end else begin : g_body
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        vld_q[s]  <= 1'b0;
                        data_q[s] <= '0;
                    end else if (advance) begin
                        vld_q[s]  <= vld_q[s-1];
                        data_q[s] <= data_q[s-1];
                    end
                end
            end
        end
    endgenerate

    assign bus.out_valid = vld_q[STAGES-1];
    assign bus.out_data  = data_q[STAGES-1];

endmodule

`default_nettype wire

// File: tb/tb_xor_lane_pipe.sv
// ============================================================================
// Module      : tb_xor_lane_pipe
// Description : Directed self-checking bench for xor_lane_pipe (8x2, 2 stages).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_xor_lane_pipe;
    localparam int WIDTH  = 8;
    localparam int LANES  = 2;
    localparam int STAGES = 2;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fails;

    xor_lane_pipe_if #(.WIDTH(WIDTH), .LANES(LANES)) bus ();

    xor_lane_pipe #(
        .WIDTH  (WIDTH),
        .LANES  (LANES),
        .STAGES (STAGES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] m, input logic clr,
                         input logic [15:0] av, input logic [15:0] bv);
        bus.in_valid = v;
        bus.mode     = m;
        bus.acc_clr  = clr;
        bus.a        = av;
        bus.b        = bv;
    endtask

    initial begin
        n_checks      = 0;
        n_fails       = 0;
        rst_n         = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b0, 2'b00, 1'b0, 16'h0000, 16'h0000);

        // Reset state and the unregistered tap
        #12;
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_out_data", {16'd0, bus.out_data}, 32'h0);
        check("rst_out_parity", {30'd0, bus.out_parity}, 32'd0);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        bus.a = 16'h0FF0;
        bus.b = 16'hFF00;
        #1;
        check("out_comb", {16'd0, bus.out_comb}, 32'hF0F0);
        @(negedge clk);
        rst_n = 1'b1;

        // XOR stream
        tick();
        drive(1'b1, 2'b00, 1'b0, 16'h1234, 16'h00FF);
        tick();
        drive(1'b1, 2'b00, 1'b0, 16'hAAAA, 16'h5555);
        tick();
        check("xor1_valid", {31'd0, bus.out_valid}, 32'd1);
        check("xor1_data", {16'd0, bus.out_data}, 32'h12CB);
        check("xor1_parity", {30'd0, bus.out_parity}, 32'd1);
        drive(1'b0, 2'b00, 1'b0, 16'h0000, 16'h0000);
        tick();
        check("xor2_data", {16'd0, bus.out_data}, 32'hFFFF);
        check("xor2_parity", {30'd0, bus.out_parity}, 32'd0);
        tick();
        check("xor_drain_valid", {31'd0, bus.out_valid}, 32'd0);

        // Accumulate, ending with clear-then-apply
        drive(1'b1, 2'b10, 1'b0, 16'h0101, 16'h0000);
        tick();
        tick();
        check("acc1", {16'd0, bus.out_data}, 32'h0101);
        tick();
        check("acc2", {16'd0, bus.out_data}, 32'h0000);
        drive(1'b1, 2'b10, 1'b1, 16'h0303, 16'h0001);
        tick();
        check("acc3", {16'd0, bus.out_data}, 32'h0101);
        drive(1'b0, 2'b10, 1'b0, 16'h0000, 16'h0000);
        tick();
        check("acc_clr_apply", {16'd0, bus.out_data}, 32'h0302);
        check("acc_clr_valid", {31'd0, bus.out_valid}, 32'd1);
        tick();

        // Backpressure in ACCUM: acc starts at 0302
        bus.out_ready = 1'b0;
        drive(1'b1, 2'b10, 1'b0, 16'h0001, 16'h0000);
        tick();
        tick();
        check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("bp_first", {16'd0, bus.out_data}, 32'h0303);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("bp_hold_data", {16'd0, bus.out_data}, 32'h0303);
            check("bp_hold_ready", {31'd0, bus.in_ready}, 32'd0);
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        tick();
        check("bp_second", {16'd0, bus.out_data}, 32'h0302);
        check("bp_second_valid", {31'd0, bus.out_valid}, 32'd1);
        tick();
        check("bp_drained", {31'd0, bus.out_valid}, 32'd0);
        drive(1'b1, 2'b10, 1'b0, 16'h0000, 16'h0000);
        tick();
        drive(1'b0, 2'b10, 1'b0, 16'h0000, 16'h0000);
        tick();
        check("bp_acc_after", {16'd0, bus.out_data}, 32'h0302);

        // XNOR and PASS
        drive(1'b1, 2'b01, 1'b0, 16'h00FF, 16'h0F0F);
        tick();
        drive(1'b1, 2'b11, 1'b0, 16'h00FF, 16'h0F0F);
        tick();
        check("xnor", {16'd0, bus.out_data}, 32'hF00F);
        drive(1'b0, 2'b00, 1'b0, 16'h0000, 16'h0000);
        tick();
        check("pass", {16'd0, bus.out_data}, 32'h00FF);
        check("pass_parity", {30'd0, bus.out_parity}, 32'd0);
        tick();

        // Reset with two ACCUM beats in flight and nonzero acc
        drive(1'b1, 2'b10, 1'b0, 16'h0005, 16'h0000);
        tick();
        drive(1'b1, 2'b10, 1'b0, 16'h0001, 16'h0000);
        tick();
        check("pre_rst_valid", {31'd0, bus.out_valid}, 32'd1);
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("async_rst_data", {16'd0, bus.out_data}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        check("post_rst_no_ghost", {31'd0, bus.out_valid}, 32'd0);
        drive(1'b1, 2'b10, 1'b0, 16'h0011, 16'h0000);
        tick();
        drive(1'b0, 2'b10, 1'b0, 16'h0000, 16'h0000);
        tick();
        check("post_rst_acc", {16'd0, bus.out_data}, 32'h0011);
        check("post_rst_valid", {31'd0, bus.out_valid}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
